// File: rtl/i2c_pkg.sv
// Shared types and helpers for the multi-channel I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } i2c_state_t;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

  function automatic logic [2:0] i2c_addr_to_ch(input logic [6:0] addr, input logic [6:0] base);
    logic [6:0] diff;
    diff = addr - base;
    return diff[2:0];
  endfunction

  function automatic logic i2c_addr_hit(input logic [6:0] addr, input logic [6:0] base,
                                        input int unsigned num_ch);
    int unsigned a;
    int unsigned b;
    a = 32'(addr);
    b = 32'(base);
    return (addr != I2C_GENERAL_CALL) && (a >= b) && (a < b + num_ch);
  endfunction

endpackage

// File: rtl/i2c_if.sv
// I2C bus bundle. SDA is open-drain: sda is the resolved bus level, sda_oe pulls it low.
interface i2c_if;
  logic scl;
  logic sda;
  logic sda_oe;

  modport target (input scl, input sda, output sda_oe);
  modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SyncStages-1:0] scl_sync_q, scl_sync_d;
  logic [SyncStages-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_prev_q, sda_prev_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SyncStages-1];
  assign sda_s = sda_sync_q[SyncStages-1];

  always_comb begin
    scl_sync_d = (scl_sync_q << 1) | SyncStages'(scl_i);
    sda_sync_d = (sda_sync_q << 1) | SyncStages'(sda_i);
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // START/STOP need SCL high on both samples so an SCL edge never masquerades as one.
  always_comb begin
    sda_o      = sda_s;
    scl_rise_o = scl_s & ~scl_prev_q;
    scl_fall_o = ~scl_s & scl_prev_q;
    start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  end

endmodule

// File: rtl/i2c_slave_mc.sv
// Multi-channel I2C target: reads stream from per-channel FWFT FIFOs, writes go out on rx_*.
module i2c_slave_mc
  import i2c_pkg::*;
#(
  parameter logic [6:0]  BASE_ADDR     = 7'h42,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_if.target                 i2c,
  input  logic [NUM_CH-1:0]     fifo_valid,
  input  logic [NUM_CH*8-1:0]   fifo_dout,
  output logic [NUM_CH-1:0]     fifo_rd_en,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [7:0]            rx_data,
  output logic [CH_W-1:0]       rx_ch,
  output logic                  busy,
  output logic                  ovf,
  output logic                  underrun
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SyncStages (SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (i2c.scl),
    .sda_i      (i2c.sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_t      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            rw_q, rw_d;
  // Second half of an ACK slot: the ACK bit is on the bus, next SCL fall ends it.
  logic            phase_q, phase_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [CH_W-1:0] rx_ch_q, rx_ch_d;
  logic            ovf_q, ovf_d;
  logic            underrun_q, underrun_d;
  logic            pop;
  logic [CH_W-1:0] pop_ch;
  logic [7:0]      rx_byte;
  logic            hit;
  logic [CH_W-1:0] hit_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ch_q       <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ch_q    <= '0;
      ovf_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ch_q    <= rx_ch_d;
      ovf_q      <= ovf_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ch_d       = ch_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ch_d    = rx_ch_q;
    ovf_d      = 1'b0;
    underrun_d = 1'b0;
    pop        = 1'b0;
    pop_ch     = ch_q;
    rx_byte    = {shift_q[6:0], sda_s};
    hit        = i2c_addr_hit(rx_byte[7:1], BASE_ADDR, NUM_CH);
    hit_ch     = CH_W'(i2c_addr_to_ch(rx_byte[7:1], BASE_ADDR));

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              rw_d    = rx_byte[0];
              if (!hit) begin
                state_d = StWaitStop;
              end else begin
                ch_d   = hit_ch;
                busy_d = 1'b1;
                if (rx_byte[0] != I2C_RW_READ) begin
                  state_d = StAddrAck;
                end else if (fifo_valid[hit_ch]) begin
                  state_d = StAddrAck;
                  shift_d = fifo_dout[{hit_ch, 3'b000} +: 8];
                  pop     = 1'b1;
                  pop_ch  = hit_ch;
                end else begin
                  state_d = StWaitStop;
                end
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q == I2C_RW_READ) begin
                state_d  = StRdByte;
                sda_oe_d = ~shift_q[7];
              end else begin
                state_d  = StWrByte;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_byte;
                rx_ch_d    = ch_q;
                rx_valid_d = 1'b1;
                phase_d    = 1'b0;
                state_d    = StWrAck;
              end else begin
                ovf_d   = 1'b1;
                state_d = StWaitStop;
              end
            end
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise && !phase_q) begin
            if (!sda_s) begin
              phase_d = 1'b1;
              if (fifo_valid[ch_q]) begin
                shift_d = fifo_dout[{ch_q, 3'b000} +: 8];
                pop     = 1'b1;
              end else begin
                shift_d    = UNDERRUN_BYTE;
                underrun_d = 1'b1;
              end
            end else begin
              state_d = StWaitStop;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            sda_oe_d  = ~shift_q[7];
            state_d   = StRdByte;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pop strobe is combinational so it coincides with the shift-register load edge.
  always_comb begin
    fifo_rd_en = '0;
    if (pop) fifo_rd_en[pop_ch] = 1'b1;
    i2c.sda_oe = sda_oe_q;
    rx_valid   = rx_valid_q;
    rx_data    = rx_data_q;
    rx_ch      = rx_ch_q;
    busy       = busy_q;
    ovf        = ovf_q;
    underrun   = underrun_q;
  end

endmodule

// File: tb/tb_i2c_slave_mc.sv
// Directed bench for i2c_slave_mc: bit-banged I2C master plus FIFO/rx monitors.
module tb_i2c_slave_mc;

  localparam int unsigned Q = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_if bus ();
  logic mscl = 1'b1;
  logic msda = 1'b1;
  assign bus.scl = mscl;
  assign bus.sda = msda & ~bus.sda_oe;

  logic [1:0]  fifo_valid;
  logic [15:0] fifo_dout = 16'h0000;
  logic [1:0]  fifo_rd_en;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic [0:0]  rx_ch;
  logic        busy, ovf, underrun;

  int checks = 0;
  int errors = 0;

  int rd_cnt0 = 0, rd_cnt1 = 0, ovf_cnt = 0, und_cnt = 0, pulse_long = 0, rx_cnt = 0;
  int lim0 = 0, lim1 = 0;
  logic [1:0] rd_prev = 2'b00;
  logic ovf_prev = 1'b0, und_prev = 1'b0;
  logic [7:0] rx_log_d [0:63];
  logic       rx_log_c [0:63];

  // FIFO model: channel c holds data until it has been popped lim<c> times in total.
  assign fifo_valid = {(rd_cnt1 < lim1), (rd_cnt0 < lim0)};

  i2c_slave_mc dut (
    .clk        (clk),
    .rst        (rst),
    .i2c        (bus),
    .fifo_valid (fifo_valid),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_ch      (rx_ch),
    .busy       (busy),
    .ovf        (ovf),
    .underrun   (underrun)
  );

  always @(posedge clk) begin
    if (fifo_rd_en[0]) rd_cnt0 <= rd_cnt0 + 1;
    if (fifo_rd_en[1]) rd_cnt1 <= rd_cnt1 + 1;
    if (ovf) ovf_cnt <= ovf_cnt + 1;
    if (underrun) und_cnt <= und_cnt + 1;
    if ((fifo_rd_en & rd_prev) != 2'b00 || (ovf && ovf_prev) || (underrun && und_prev))
      pulse_long <= pulse_long + 1;
    rd_prev  <= fifo_rd_en;
    ovf_prev <= ovf;
    und_prev <= underrun;
    if (rx_valid && rx_ready) begin
      rx_log_d[rx_cnt % 64] <= rx_data;
      rx_log_c[rx_cnt % 64] <= rx_ch[0];
      rx_cnt <= rx_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    msda = 1'b1; wt(Q);
    mscl = 1'b1; wt(Q);
    msda = 1'b0; wt(Q);
    mscl = 1'b0; wt(2);
  endtask

  task automatic m_stop();
    msda = 1'b0; wt(Q);
    mscl = 1'b1; wt(Q);
    msda = 1'b1; wt(Q);
  endtask

  task automatic m_bit_w(input logic b);
    msda = b; wt(Q);
    mscl = 1'b1; wt(Q);
    mscl = 1'b0; wt(2);
  endtask

  task automatic m_bit_r(output logic b);
    msda = 1'b1; wt(Q);
    mscl = 1'b1; wt(Q / 2);
    b = bus.sda;
    wt(Q - Q / 2);
    mscl = 1'b0; wt(2);
  endtask

  task automatic m_write(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) m_bit_w(d[i]);
    m_bit_r(b);
    ack = ~b;
  endtask

  task automatic m_read(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_bit_r(b);
      d[i] = b;
    end
    m_bit_w(~ack);
  endtask

  task automatic test_reset();
    rst = 1'b1; wt(3);
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (fifo_rd_en !== 2'b00) begin errors++; $display("FAIL reset_rd_en: got %b expected 00", fifo_rd_en); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_ch !== 1'b0) begin errors++; $display("FAIL reset_rx_ch: got %b expected 0", rx_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({ovf, underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {ovf, underrun}); end
    rst = 1'b0; wt(3);
  endtask

  task automatic test_read_ch1();
    logic ack; logic [7:0] d; int r0, r1;
    fifo_dout = 16'hA533; lim1 = rd_cnt1 + 1; lim0 = rd_cnt0;
    r0 = rd_cnt0; r1 = rd_cnt1;
    m_start();
    m_write(8'h87, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b expected 1", busy); end
    m_read(d, 1'b0);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_byte: got %h expected a5", d); end
    m_stop(); wt(4);
    checks++; if (rd_cnt1 - r1 !== 1) begin errors++; $display("FAIL read_pop_ch1: got %0d expected 1", rd_cnt1 - r1); end
    checks++; if (rd_cnt0 - r0 !== 0) begin errors++; $display("FAIL read_pop_ch0: got %0d expected 0", rd_cnt0 - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2; int n;
    rx_ready = 1'b1; n = rx_cnt;
    m_start();
    m_write(8'h84, a0);
    m_write(8'h3C, a1);
    m_write(8'h81, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
    m_stop(); wt(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
    checks++; if (rx_cnt - n !== 2) begin errors++; $display("FAIL write_beats: got %0d expected 2", rx_cnt - n); end
    checks++; if ({rx_log_d[n % 64], rx_log_c[n % 64]} !== {8'h3C, 1'b0})
      begin errors++; $display("FAIL write_beat0: got %h/%b expected 3c/0", rx_log_d[n % 64], rx_log_c[n % 64]); end
    checks++; if ({rx_log_d[(n + 1) % 64], rx_log_c[(n + 1) % 64]} !== {8'h81, 1'b0})
      begin errors++; $display("FAIL write_beat1: got %h/%b expected 81/0", rx_log_d[(n + 1) % 64], rx_log_c[(n + 1) % 64]); end
  endtask

  task automatic test_bad_addr();
    logic a0, a1, a2; int n, r0, r1;
    lim0 = rd_cnt0 + 100; lim1 = rd_cnt1 + 100;
    n = rx_cnt; r0 = rd_cnt0; r1 = rd_cnt1;
    m_start(); m_write(8'hA0, a0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy: got %b expected 0", busy); end
    m_stop();
    m_start(); m_write(8'h00, a1); m_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL bad_addr_nack: got %b expected 00", {a0, a1}); end
    checks++; if ((rd_cnt0 - r0) + (rd_cnt1 - r1) + (rx_cnt - n) !== 0)
      begin errors++; $display("FAIL bad_addr_side_effects: got %0d expected 0", (rd_cnt0 - r0) + (rd_cnt1 - r1) + (rx_cnt - n)); end
    m_start(); m_write(8'h84, a2); m_stop();
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL bad_addr_recover: got %b expected 1", a2); end
    lim0 = rd_cnt0; lim1 = rd_cnt1;
  endtask

  task automatic test_overflow();
    logic a0, a1, a2; int o, n;
    rx_ready = 1'b0; o = ovf_cnt; n = rx_cnt;
    m_start();
    m_write(8'h84, a0);
    m_write(8'h11, a1);
    m_write(8'h22, a2);
    checks++; if ({a0, a1, a2} !== 3'b110) begin errors++; $display("FAIL ovf_acks: got %b expected 110", {a0, a1, a2}); end
    m_stop(); wt(4);
    checks++; if (ovf_cnt - o !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt - o); end
    checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL ovf_held: got %b/%h expected 1/11", rx_valid, rx_data); end
    rx_ready = 1'b1; wt(2);
    checks++; if (rx_cnt - n !== 1 || rx_log_d[n % 64] !== 8'h11)
      begin errors++; $display("FAIL ovf_drain: got %0d beats data %h expected 1 beat 11", rx_cnt - n, rx_log_d[n % 64]); end
  endtask

  task automatic test_underrun();
    logic ack; logic [7:0] d1, d2; int r0, u;
    fifo_dout = 16'h005A; lim0 = rd_cnt0 + 1; r0 = rd_cnt0; u = und_cnt;
    m_start();
    m_write(8'h85, ack);
    m_read(d1, 1'b1);
    m_read(d2, 1'b0);
    m_stop(); wt(4);
    checks++; if ({ack, d1, d2} !== {1'b1, 8'h5A, 8'hFF}) begin errors++; $display("FAIL underrun_bytes: got %b/%h/%h expected 1/5a/ff", ack, d1, d2); end
    checks++; if (rd_cnt0 - r0 !== 1) begin errors++; $display("FAIL underrun_pops: got %0d expected 1", rd_cnt0 - r0); end
    checks++; if (und_cnt - u !== 1) begin errors++; $display("FAIL underrun_pulses: got %0d expected 1", und_cnt - u); end
    checks++; if (pulse_long !== 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", pulse_long); end
  endtask

  task automatic test_rst_mid();
    logic a0, a1, a2;
    rx_ready = 1'b0; fifo_dout = 16'h0000;
    m_start();
    m_write(8'h84, a0);
    m_write(8'h77, a1);
    lim0 = rd_cnt0 + 1;
    m_start();
    m_write(8'h85, a2);
    wt(4);
    checks++; if ({a0, a1, a2, bus.sda_oe, rx_valid} !== 5'b11111)
      begin errors++; $display("FAIL rst_mid_setup: got %b expected 11111", {a0, a1, a2, bus.sda_oe, rx_valid}); end
    rst = 1'b1; wt(1);
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_sda: got %b expected 0", bus.sda_oe); end
    checks++; if ({rx_valid, rx_data, busy, fifo_rd_en, ovf, underrun} !== 14'h0)
      begin errors++; $display("FAIL rst_mid_outputs: got %b/%h/%b/%b/%b/%b expected all 0", rx_valid, rx_data, busy, fifo_rd_en, ovf, underrun); end
    rst = 1'b0; rx_ready = 1'b1; lim0 = rd_cnt0;
    msda = 1'b1; mscl = 1'b1; wt(Q);
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2; logic [7:0] d; int n, r1;
    rx_ready = 1'b1; fifo_dout = 16'hC300; lim1 = rd_cnt1 + 1; n = rx_cnt; r1 = rd_cnt1;
    m_start();
    m_write(8'h84, a0);
    m_write(8'h12, a1);
    m_start();
    m_write(8'h87, a2);
    m_read(d, 1'b0);
    m_stop(); wt(4);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rstart_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rstart_byte: got %h expected c3", d); end
    checks++; if (rd_cnt1 - r1 !== 1) begin errors++; $display("FAIL rstart_pop: got %0d expected 1", rd_cnt1 - r1); end
    checks++; if (rx_cnt - n !== 1 || rx_log_d[n % 64] !== 8'h12)
      begin errors++; $display("FAIL rstart_write: got %0d beats data %h expected 1 beat 12", rx_cnt - n, rx_log_d[n % 64]); end
  endtask

  initial begin
    test_reset();
    test_read_ch1();
    test_write();
    test_bad_addr();
    test_overflow();
    test_underrun();
    test_rst_mid();
    test_repeated_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
